display_module_mux_nd: RTL and testbench

//  Time-multiplexed N-digit hex 7-segment driver for board debug readout.

---
 rtl/display_pkg.sv | 34 +++
 rtl/display_module_async.sv | 11 +
 rtl/display_module_mux_nd.sv | 176 +++++++++++++++++
 tb/tb_display_module_mux_nd.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the scanned hex 7-segment display.
package display_pkg;

    // Blink phase of the whole display; blink-enabled digits go dark in HIDDEN.
    typedef enum logic {
        VISIBLE = 1'b0,
        HIDDEN  = 1'b1
    } blink_state_e;

    // Ceiling log2 with a minimum of 1, so a one-entry counter still has a bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts lit segments (1 = lit) to pin levels.
    function automatic logic [7:0] seg_level(input logic [7:0] lit, input bit active_low);
        return active_low ? ~lit : lit;
    endfunction

    // Converts a digit-enable request (1 = drive) to the pin level.
    function automatic logic dig_level(input logic asserted, input bit active_low);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/display_module_async.sv
// Combinational hex-to-7-segment decoder; active-high output, bit 0 = segment a.
module display_module_async
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX7SEG[hex];

endmodule

// File: rtl/display_module_mux_nd.sv
// Time-multiplexed N-digit hex 7-segment driver: one shared segment bus, one
// enable per digit, with leading-zero blanking, per-digit DP and blink,
// dead time at each slot start, and display updates only at frame boundaries.
module display_module_mux_nd
    import display_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data_i,
    input  logic                load_i,
    input  logic                lz_blank_i,
    input  logic [DIGITS-1:0]   dp_i,
    input  logic [DIGITS-1:0]   blink_i,
    output logic [7:0]          seg_o,
    output logic [DIGITS-1:0]   dig_o,
    output logic                frame_o
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int PRE_W = clog2(REFRESH_DIV);
    localparam int BLK_W = clog2(BLINK_FRAMES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    if (REFRESH_DIV < DEAD_CYCLES + 2) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be at least DEAD_CYCLES+2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [PRE_W-1:0]    presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BLK_W-1:0]    blk_cnt_q;
    blink_state_e        blink_state_q, blink_state_d;

    logic [4*DIGITS-1:0] shadow_data_q, disp_data_q;
    logic [DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic [DIGITS-1:0]   shadow_blink_q, disp_blink_q;
    logic                lz_en_q;

    logic                presc_term, frame_end, blk_wrap;
    logic [DIGITS-1:0]   lz_mask;
    logic                lz_run;
    logic [IDX_W+1:0]    nib_base;
    logic [3:0]          cur_nibble;
    logic [6:0]          dec_seg;
    logic                slot_active, hidden, digit_blank;
    logic [7:0]          seg_lit;

    assign presc_term = (presc_q == PRE_LAST);
    assign frame_end  = presc_term && (idx_q == IDX_LAST);
    assign blk_wrap   = (blk_cnt_q == BLK_LAST);

    // Slot prescaler and scan index; frame_o marks the first cycle of slot 0.
    // NOTE: non-blocking assignments make every register update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_o <= 1'b0;
        end else begin
            presc_q <= presc_term ? '0 : presc_q + 1'b1;
            if (presc_term) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            frame_o <= frame_end;
        end
    end

    // Blink frame counter and phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q     <= '0;
            blink_state_q <= VISIBLE;
        end else begin
            if (frame_end) begin
                blk_cnt_q <= blk_wrap ? '0 : blk_cnt_q + 1'b1;
            end
            blink_state_q <= blink_state_d;
        end
    end

    // Blink phase toggles each time the frame counter wraps.
    // NOTE: the default assignment first covers every path, so no latch is inferred.
    always_comb begin
        blink_state_d = blink_state_q;
        if (frame_end && blk_wrap) begin
            case (blink_state_q)
                VISIBLE: blink_state_d = HIDDEN;
                HIDDEN:  blink_state_d = VISIBLE;
                default: blink_state_d = VISIBLE;
            endcase
        end
    end

    // Shadow capture on load; display copy only at the frame boundary, with a
    // same-cycle load bypassing the shadow so the new frame shows it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blink_q <= '0;
            disp_data_q    <= '0;
            disp_dp_q      <= '0;
            disp_blink_q   <= '0;
            lz_en_q        <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_data_q  <= data_i;
                shadow_dp_q    <= dp_i;
                shadow_blink_q <= blink_i;
            end
            if (frame_end) begin
                disp_data_q  <= load_i ? data_i  : shadow_data_q;
                disp_dp_q    <= load_i ? dp_i    : shadow_dp_q;
                disp_blink_q <= load_i ? blink_i : shadow_blink_q;
                lz_en_q      <= lz_blank_i;
            end
        end
    end

    // Leading-zero mask: digit i>0 is blank when it and every higher nibble are 0.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run & (disp_data_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    assign nib_base   = {idx_q, 2'b00};
    assign cur_nibble = disp_data_q[nib_base +: 4];

    display_module_async u_decoder (
        .hex (cur_nibble),
        .seg (dec_seg)
    );

    // Lit pattern for the current slot before polarity is applied.
    always_comb begin
        slot_active = (presc_q >= PRE_DEAD);
        hidden      = (blink_state_q == HIDDEN) && disp_blink_q[idx_q];
        digit_blank = hidden || (lz_en_q && lz_mask[idx_q]);
        seg_lit     = 8'h00;
        if (slot_active) begin
            seg_lit[6:0] = digit_blank ? 7'h00 : dec_seg;
            seg_lit[7]   = disp_dp_q[idx_q] && !hidden;
        end
    end

    // Registered pin drivers; at most one digit enable is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= seg_level(8'h00, SEG_ACTIVE_LOW);
            dig_o <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            seg_o <= seg_level(seg_lit, SEG_ACTIVE_LOW);
            for (int i = 0; i < DIGITS; i++) begin
                dig_o[i] <= dig_level(slot_active && (idx_q == IDX_W'(i)), DIG_ACTIVE_LOW);
            end
        end
    end

endmodule

// File: tb/tb_display_module_mux_nd.sv
// Self-checking bench for display_module_mux_nd with a time-based reference model.
module tb_display_module_mux_nd;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic        load_i = 1'b0;
    logic        lz_blank_i = 1'b0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blink_i = '0;
    logic [7:0]  seg_o;
    logic [3:0]  dig_o;
    logic        frame_o;

    int total = 0;
    int bad = 0;

    // Reference model: n counts clock edges since reset release.
    int          n;
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dp, m_blink, s_dp, s_blink;
    logic        m_lz;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_frame;

    display_module_mux_nd #(
        .DIGITS         (4),
        .REFRESH_DIV    (8),
        .DEAD_CYCLES    (2),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .load_i     (load_i),
        .lz_blank_i (lz_blank_i),
        .dp_i       (dp_i),
        .blink_i    (blink_i),
        .seg_o      (seg_o),
        .dig_o      (dig_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_hex(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        m_data = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0;
        s_data = '0; s_dp = '0; s_blink = '0;
    endtask

    // One clock: predict the outputs this edge produces (slot = 8 cycles,
    // frame = 32 cycles, blink half-period = 2 frames), then apply loads.
    task automatic tick();
        int s, p, d;
        bit hid, lzb;
        logic [3:0] nib;
        @(posedge clk);
        s = n;
        p = s % 8;
        d = (s / 8) % 4;
        exp_frame = (s % 32 == 31);
        if (p < 2) begin
            exp_dig = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            nib = m_data[4*d +: 4];
            hid = ((s / 64) % 2 == 1) && m_blink[d];
            lzb = m_lz && (d > 0) && ((m_data >> (4*d)) == 16'h0);
            exp_dig = ~(4'b0001 << d);
            exp_seg = ~{m_dp[d] && !hid, (hid || lzb) ? 7'h00 : ref_hex(nib)};
        end
        if (exp_frame) begin
            if (load_i) begin
                m_data = data_i; m_dp = dp_i; m_blink = blink_i;
            end else begin
                m_data = s_data; m_dp = s_dp; m_blink = s_blink;
            end
            m_lz = lz_blank_i;
        end
        if (load_i) begin
            s_data = data_i; s_dp = dp_i; s_blink = blink_i;
        end
        n++;
        #1;
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dig_o !== 4'hF) begin bad++; $display("FAIL reset_dig got=%h want=F", dig_o); end
        total++;
        if (seg_o !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=FF", seg_o); end
        total++;
        if (frame_o !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", frame_o); end
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (first < 0 && dig_o !== 4'hF) first = i;
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL reset_run n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
        total++;
        if (first != 3) begin bad++; $display("FAIL first_enable got cycle %0d want 3", first); end
    endtask

    task automatic test_scan();
        lz_blank_i = 1'b0; dp_i = '0; blink_i = '0;
        for (int k = 0; k < 128; k++) begin
            load_i = 1'b0;
            if (n % 32 == 5) begin
                load_i = 1'b1;
                data_i = (k < 32) ? 16'h1234 : 16'($urandom);
                dp_i   = (k < 64) ? 4'h0 : 4'($urandom);
            end
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL scan n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_lz();
        lz_blank_i = 1'b1; dp_i = '0; blink_i = '0;
        for (int k = 0; k < 128; k++) begin
            load_i = 1'b0;
            if (n % 32 == 5) begin
                load_i = 1'b1;
                data_i = (k < 64) ? 16'h0030 : 16'h0000;
            end
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL lz n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
        load_i = 1'b0;
        lz_blank_i = 1'b0;
    endtask

    task automatic test_blink_dp();
        bit loaded;
        loaded = 1'b0;
        lz_blank_i = 1'b0;
        for (int k = 0; k < 224; k++) begin
            load_i = 1'b0;
            if (!loaded && n % 32 == 5) begin
                load_i  = 1'b1;
                loaded  = 1'b1;
                data_i  = 16'($urandom) | 16'h0008;
                dp_i    = 4'b0010;
                blink_i = 4'b0001;
            end
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL blink n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
            if (k >= 64 && dig_o === 4'b1101) begin
                total++;
                if (seg_o[7] !== 1'b0) begin bad++; $display("FAIL dp_digit1 got=%b want=0", seg_o[7]); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_tear_free();
        bit a_done, b_done;
        int b_left;
        a_done = 1'b0; b_done = 1'b0; b_left = 0;
        lz_blank_i = 1'b0; dp_i = '0; blink_i = '0;
        for (int k = 0; k < 128; k++) begin
            load_i = 1'b0;
            if (!a_done && n % 32 == 10) begin
                load_i = 1'b1; data_i = 16'hAAAA; a_done = 1'b1;
            end else if (a_done && !b_done && n % 32 == 31) begin
                load_i = 1'b1; data_i = 16'hBBBB; b_done = 1'b1; b_left = 33;
            end
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL tear n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
            if (b_left > 0) begin
                b_left--;
                if (b_left < 32 && dig_o !== 4'hF) begin
                    total++;
                    if (seg_o !== 8'h83) begin bad++; $display("FAIL tear_all_b got=%h want=83", seg_o); end
                end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 256; k++) begin
            load_i     = ($urandom_range(0, 5) == 0);
            data_i     = 16'($urandom);
            dp_i       = 4'($urandom);
            blink_i    = 4'($urandom);
            lz_blank_i = 1'($urandom);
            if ($urandom_range(0, 3) == 0) data_i = data_i & 16'h00FF;
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL random n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
        load_i = 1'b0;
        lz_blank_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit loaded;
        loaded = 1'b0;
        lz_blank_i = 1'b0; dp_i = '0; blink_i = '0;
        for (int k = 0; k < 70; k++) begin
            if (loaded && n % 32 == 21) break;
            load_i = 1'b0;
            if (!loaded && n % 32 == 15) begin
                load_i = 1'b1; data_i = 16'h5A5A; dp_i = 4'hF; loaded = 1'b1;
            end
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL pre_reset n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
        load_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (dig_o !== 4'hF || seg_o !== 8'hFF || frame_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset dig=%h seg=%h frame=%b want F FF 0", dig_o, seg_o, frame_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 80; k++) begin
            tick();
            total++;
            if (seg_o !== exp_seg || dig_o !== exp_dig || frame_o !== exp_frame) begin
                bad++;
                $display("FAIL post_reset n=%0d seg=%h want %h dig=%h want %h frame=%b want %b",
                         n - 1, seg_o, exp_seg, dig_o, exp_dig, frame_o, exp_frame);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_lz();
        test_blink_dp();
        test_tear_free();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
